// File: rtl/md5_match_checker.sv
// Two-stage digest comparator that watches the md5core output stream
// and latches the message whose digest matches a loaded target.
module md5_match_checker #(
    parameter int MSG_BITS = 152,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                target_load,
    input  logic [127:0]        target_hash,
    input  logic [31:0]         a_in,
    input  logic [31:0]         b_in,
    input  logic [31:0]         c_in,
    input  logic [31:0]         d_in,
    input  logic [MSG_BITS-1:0] m_in,
    input  logic                valid_in,
    input  logic                match_ack,
    output logic                armed,
    output logic                match,
    output logic [MSG_BITS-1:0] match_mesg,
    output logic                extra_match,
    output logic [CNT_BITS-1:0] hash_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MATCHED
    } state_t;

    state_t              state;
    logic [127:0]        target;
    logic [3:0]          eq1;
    logic                v1;
    logic [MSG_BITS-1:0] m1;
    logic                hit2;
    logic [MSG_BITS-1:0] m2;

    assign armed = (state == ARMED);
    assign match = (state == MATCHED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            target      <= '0;
            eq1         <= '0;
            v1          <= 1'b0;
            m1          <= '0;
            hit2        <= 1'b0;
            m2          <= '0;
            match_mesg  <= '0;
            extra_match <= 1'b0;
            hash_count  <= '0;
        end else if (en) begin
            // Stage 1: per-word equality against the current target
            eq1 <= {a_in == target[127:96],
                    b_in == target[95:64],
                    c_in == target[63:32],
                    d_in == target[31:0]};
            m1  <= m_in;
            v1  <= valid_in & ~target_load;
            // Stage 2: reduce to a single hit
            hit2 <= v1 & (&eq1) & ~target_load;
            m2   <= m1;

            if (target_load) begin
                target      <= target_hash;
                hash_count  <= '0;
                extra_match <= 1'b0;
                match_mesg  <= '0;
                state       <= ARMED;
            end else begin
                if (v1 && state != IDLE && hash_count != '1)
                    hash_count <= hash_count + CNT_BITS'(1);
                unique case (state)
                    IDLE: ;
                    ARMED: begin
                        if (hit2) begin
                            state      <= MATCHED;
                            match_mesg <= m2;
                        end
                    end
                    MATCHED: begin
                        // A hit coinciding with the ack is dropped
                        if (match_ack) begin
                            state       <= ARMED;
                            extra_match <= 1'b0;
                        end else if (hit2) begin
                            extra_match <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
